// File: rtl/trace_arb_pkg.sv
// Shared types and constants for the trace channel arbiter.
package trace_arb_pkg;

    localparam int unsigned N_DEFAULT  = 2;
    localparam int unsigned W_DEFAULT  = 8;
    localparam int unsigned DROP_CNT_W = 16;

    // Source index width: ceil(log2(n)), never below one bit.
    function automatic int unsigned src_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    typedef logic [src_width(N_DEFAULT)-1:0] src_idx_t;

endpackage

// File: rtl/trace_channel_arbiter_rr_pick.sv
// Combinational round-robin picker: first set req bit at or after ptr, wrapping.
module rr_pick
    import trace_arb_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT
) (
    input  logic [N-1:0]              req,
    input  logic [src_width(N)-1:0]   ptr,
    input  logic                      en,
    output logic [N-1:0]              grant,
    output logic [src_width(N)-1:0]   winner,
    output logic                      any
);

    localparam int unsigned SW = src_width(N);

    logic [SW-1:0] idx;

    // Scan ptr, ptr+1, ..., wrapping modulo N; the first hit wins.
    always_comb begin
        grant  = '0;
        winner = '0;
        any    = 1'b0;
        idx    = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = SW'((32'(ptr) + k) % N);
            if (en && req[idx] && !any) begin
                any        = 1'b1;
                grant[idx] = 1'b1;
                winner     = idx;
            end
        end
    end

endmodule

// File: rtl/trace_channel_arbiter.sv
// Shares one registered trace output among N requesters, one holding buffer each,
// round-robin grant, saturating stall counter.
module trace_channel_arbiter
    import trace_arb_pkg::*;
#(
    parameter int unsigned N = N_DEFAULT,
    parameter int unsigned W = W_DEFAULT
) (
    input  logic                    CLK,
    input  logic                    RESETN,
    input  logic [N-1:0]            req_valid,
    input  logic [N*W-1:0]          req_data,
    output logic [N-1:0]            req_ready,
    output logic                    out_valid,
    output logic [W-1:0]            out_data,
    output logic [src_width(N)-1:0] out_src,
    input  logic                    out_ready,
    output logic [DROP_CNT_W-1:0]   drop_cnt
);

    localparam int unsigned SW = src_width(N);

    logic [N-1:0]          buf_full;
    logic [N-1:0][W-1:0]   buf_data;
    logic [SW-1:0]         ptr;

    logic                  load;
    logic [N-1:0]          grant;
    logic [SW-1:0]         winner;
    logic                  any_grant;
    logic [N-1:0]          accept;
    logic                  stall;

    // Output register may take a new payload when empty or being drained.
    assign load = ~out_valid | out_ready;

    rr_pick #(
        .N (N)
    ) u_pick (
        .req    (buf_full),
        .ptr    (ptr),
        .en     (load),
        .grant  (grant),
        .winner (winner),
        .any    (any_grant)
    );

    // A buffer accepts when empty or when it is emptied by a grant this cycle.
    assign req_ready = {N{RESETN}} & (~buf_full | grant);
    assign accept    = req_valid & req_ready;
    assign stall     = |(req_valid & ~req_ready);

    // Holding buffers: refill wins over a same-cycle grant.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            buf_full <= '0;
            buf_data <= '0;
        end else begin
            for (int unsigned i = 0; i < N; i++) begin
                if (accept[i]) begin
                    buf_full[i] <= 1'b1;
                    buf_data[i] <= req_data[i*W +: W];
                end else if (grant[i]) begin
                    buf_full[i] <= 1'b0;
                end
            end
        end
    end

    // Output register and round-robin pointer; both hold while the sink stalls.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_src   <= '0;
            ptr       <= '0;
        end else if (load) begin
            if (any_grant) begin
                out_valid <= 1'b1;
                out_data  <= buf_data[winner];
                out_src   <= winner;
                ptr       <= (32'(winner) == N - 1) ? '0 : winner + SW'(1);
            end else begin
                out_valid <= 1'b0;
            end
        end
    end

    // Saturating count of cycles in which any requester was held off.
    always_ff @(posedge CLK) begin
        if (!RESETN) begin
            drop_cnt <= '0;
        end else if (stall && (drop_cnt != {DROP_CNT_W{1'b1}})) begin
            drop_cnt <= drop_cnt + DROP_CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_trace_channel_arbiter.sv
// Bench for trace_channel_arbiter: per-cycle reference model plus directed scenarios.
module tb_trace_channel_arbiter;

    localparam int NREQ = 2;
    localparam int WD   = 8;

    logic             CLK = 1'b0;
    logic             rstn;
    logic [NREQ-1:0]  rv;
    logic [NREQ*WD-1:0] rd;
    logic [NREQ-1:0]  req_ready;
    logic             out_valid;
    logic [WD-1:0]    out_data;
    logic [0:0]       out_src;
    logic             ordy;
    logic [15:0]      drop_cnt;

    int n_cmp = 0;
    int n_bad = 0;

    trace_channel_arbiter #(.N(NREQ), .W(WD)) dut (
        .CLK       (CLK),
        .RESETN    (rstn),
        .req_valid (rv),
        .req_data  (rd),
        .req_ready (req_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_src   (out_src),
        .out_ready (ordy),
        .drop_cnt  (drop_cnt)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // ---------------- reference model (spec-level, evaluated mid-cycle) ----------------
    bit           m_init = 1'b0;
    bit           m_full [NREQ];
    logic [WD-1:0] m_data [NREQ];
    int           m_ptr;
    bit           m_ov;
    logic [WD-1:0] m_od;
    int           m_os;
    int           m_drop;
    bit           m_load;
    int           m_w;
    logic [NREQ-1:0] m_rdy;
    logic [WD-1:0] sbq [NREQ][$];
    logic [WD-1:0] sb_exp;

    always @(negedge CLK) begin
        // Who would win at the coming edge, and who may hand over a payload.
        m_load = !m_ov || ordy;
        m_w = -1;
        if (m_load)
            for (int k = 0; k < NREQ; k++)
                if (m_w < 0 && m_full[(m_ptr + k) % NREQ]) m_w = (m_ptr + k) % NREQ;
        for (int i = 0; i < NREQ; i++)
            m_rdy[i] = rstn && (!m_full[i] || m_w == i);

        if (m_init) begin
            chk("req_ready", 32'(req_ready), 32'(m_rdy));
            chk("out_valid", 32'(out_valid), 32'(m_ov));
            if (m_ov) begin
                chk("out_data", 32'(out_data), 32'(m_od));
                chk("out_src", 32'(out_src), 32'(m_os));
            end
            chk("drop_cnt", 32'(drop_cnt), 32'(m_drop));
            // Per-source ordering: every emitted payload must be the oldest accepted one.
            if (rstn && out_valid && ordy) begin
                n_cmp++;
                if (sbq[out_src].size() == 0) begin
                    n_bad++;
                    $display("FAIL sb_order: got %0h from src %0d, expected nothing pending", out_data, out_src);
                end else begin
                    sb_exp = sbq[out_src].pop_front();
                    if (out_data !== sb_exp) begin
                        n_bad++;
                        $display("FAIL sb_order: got %0h, expected %0h (src %0d)", out_data, sb_exp, out_src);
                    end
                end
            end
        end

        // Advance the model across the coming edge.
        if (!rstn) begin
            m_init = 1'b1;
            for (int i = 0; i < NREQ; i++) begin
                m_full[i] = 1'b0;
                m_data[i] = '0;
                sbq[i].delete();
            end
            m_ptr = 0; m_ov = 1'b0; m_od = '0; m_os = 0; m_drop = 0;
        end else begin
            if (|(rv & ~m_rdy) && m_drop < 65535) m_drop++;
            if (m_w >= 0) begin
                m_ov = 1'b1;
                m_od = m_data[m_w];
                m_os = m_w;
                m_ptr = (m_w + 1) % NREQ;
                m_full[m_w] = 1'b0;
            end else if (m_load) begin
                m_ov = 1'b0;
            end
            for (int i = 0; i < NREQ; i++)
                if (rv[i] && m_rdy[i]) begin
                    m_full[i] = 1'b1;
                    m_data[i] = rd[i*WD +: WD];
                    sbq[i].push_back(rd[i*WD +: WD]);
                end
        end
    end

    // ---------------- directed stimulus with literal expectations ----------------
    int n0, n1, prev_src, emit_cnt, held_d, held_s, drop0;
    int exp_n [NREQ];
    logic [NREQ-1:0] rdy_s;

    initial begin
        rv = '0; rd = '0; ordy = 1'b0; rstn = 1'b0;

        // Reset then idle.
        tick(); tick();
        chk("rst_out_valid", 32'(out_valid), 32'h0);
        chk("rst_drop_cnt", 32'(drop_cnt), 32'h0);
        rstn = 1'b1; ordy = 1'b1;
        #1 chk("idle_req_ready", 32'(req_ready), 32'h3);
        tick();
        chk("idle_out_valid", 32'(out_valid), 32'h0);

        // Single source, two-cycle latency.
        rv = 2'b01; rd = 16'h00A5;
        tick();
        rv = 2'b00;
        tick();
        chk("single_valid", 32'(out_valid), 32'h1);
        chk("single_data", 32'(out_data), 32'hA5);
        chk("single_src", 32'(out_src), 32'h0);
        tick();
        chk("single_drained", 32'(out_valid), 32'h0);

        // Back-to-back 01..04 with no bubbles.
        for (int j = 0; j < 6; j++) begin
            rv = (j < 4) ? 2'b01 : 2'b00;
            rd = {8'h00, 8'(j + 1)};
            tick();
            if (j >= 1 && j <= 4) begin
                chk("b2b_valid", 32'(out_valid), 32'h1);
                chk("b2b_data", 32'(out_data), 32'(j));
            end
        end
        chk("b2b_drained", 32'(out_valid), 32'h0);

        // Fairness: both stream; sources alternate and stay in order.
        n0 = 0; n1 = 0; prev_src = -1; exp_n[0] = 0; exp_n[1] = 0;
        for (int j = 0; j < 12; j++) begin
            rv = 2'b11; rd = {8'(32 + n1), 8'(16 + n0)}; ordy = 1'b1;
            #1 rdy_s = req_ready;
            if (out_valid) begin
                if (prev_src >= 0) chk("fair_alternate", 32'(out_src), 32'(1 - prev_src));
                chk("fair_in_order", 32'(out_data), 32'((out_src ? 32 : 16) + exp_n[out_src]));
                exp_n[out_src]++;
                prev_src = int'(out_src);
            end
            tick();
            if (rdy_s[0]) n0++;
            if (rdy_s[1]) n1++;
        end
        chk("fair_emitted", 32'(exp_n[0] + exp_n[1]), 32'd10);

        // Backpressure with both buffers full.
        held_d = int'(out_data); held_s = int'(out_src); drop0 = int'(drop_cnt);
        chk("bp_pre_valid", 32'(out_valid), 32'h1);
        for (int j = 0; j < 5; j++) begin
            rv = 2'b11; rd = {8'(32 + n1), 8'(16 + n0)}; ordy = 1'b0;
            #1 chk("bp_req_ready", 32'(req_ready), 32'h0);
            chk("bp_data_stable", 32'(out_data), 32'(held_d));
            chk("bp_src_stable", 32'(out_src), 32'(held_s));
            tick();
        end
        chk("bp_drop_plus5", 32'(drop_cnt), 32'(drop0 + 5));
        rv = 2'b00; ordy = 1'b1; emit_cnt = 0;
        for (int j = 0; j < 4; j++) begin
            #1 if (out_valid) emit_cnt++;
            tick();
        end
        chk("bp_drain_count", 32'(emit_cnt), 32'd3);
        chk("bp_sb_empty0", 32'(sbq[0].size()), 32'd0);
        chk("bp_sb_empty1", 32'(sbq[1].size()), 32'd0);

        // Reset mid-stream with both buffers and the output full.
        n0 = 0; n1 = 0;
        for (int j = 0; j < 3; j++) begin
            rv = 2'b11; rd = {8'(64 + n1), 8'(48 + n0)}; ordy = 1'b0;
            #1 rdy_s = req_ready;
            tick();
            if (rdy_s[0]) n0++;
            if (rdy_s[1]) n1++;
        end
        chk("mr_pre_valid", 32'(out_valid), 32'h1);
        chk("mr_pre_ready", 32'(req_ready), 32'h0);
        rstn = 1'b0; rv = 2'b00; ordy = 1'b1;
        tick();
        chk("mr_out_valid", 32'(out_valid), 32'h0);
        chk("mr_ptr", 32'(dut.ptr), 32'h0);
        rstn = 1'b1;
        for (int j = 0; j < 4; j++) begin
            #1 chk("mr_no_ghost", 32'(out_valid), 32'h0);
            tick();
        end

        // Drop counter saturation.
        rv = 2'b01; rd = 16'h0077; ordy = 1'b0;
        for (int j = 0; j < 70000; j++) tick();
        chk("sat_drop_cnt", 32'(drop_cnt), 32'hFFFF);
        tick();
        chk("sat_drop_hold", 32'(drop_cnt), 32'hFFFF);

        rv = 2'b00;
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
